timer_wb8: RTL
==============

Name: timer_wb8

Overview:
- Memory-mapped 32-bit timer with compare interrupt. It is a Wishbone 8-bit responder on the CPU data bus, decoded by the bus arbiter into its own address region.
- Its O_irq output drives the CPU INTERRUPT_I input.
- Firmware reads and writes the counter, compare, control and prescaler registers bytewise.
- It gives the CPU a periodic/one-shot interrupt source and a free-running time base.

Parameters:
- COUNTER_RESET, 32'h00000000, counter value after reset
- COMPARE_RESET, 32'hFFFFFFFF, compare value after reset

Ports:
- I_wb_clk  in  1  system clock; all logic on rising edge
- I_reset_n  in  1  asynchronous active-low reset
- I_wb_stb  in  1  strobe; the cycle is a bus request
- I_wb_we  in  1  1 = write, 0 = read
- I_wb_adr  in  4  byte register address
- I_wb_dat  in  8  write data
- O_wb_dat  out  8  read data, valid while O_wb_ack = 1
- O_wb_ack  out  1  one-cycle acknowledge
- O_wb_stall  out  1  constant 0; the block never stalls
- O_irq  out  1  level interrupt request to the CPU

Behaviour:
- Register map (I_wb_adr):
  - 0..3: COUNTER bytes, little-endian
  - 4..7: COMPARE bytes
  - 8: CTRL; bit0 EN, bit1 IE, bit2 PEND (read; write 1 clears), other bits read 0
  - 9: PRESCALE, 8 bit
  - 10..15: read 0, writes ignored, still acked
- Reset while I_reset_n = 0 takes effect immediately, even mid-transaction:
  - COUNTER = COUNTER_RESET, COMPARE = COMPARE_RESET
  - CTRL = 0, PRESCALE = 0, prescaler count = 0
  - O_wb_ack = 0, O_wb_dat = 0, O_irq = 0
  - Any transaction in flight is dropped; no ack is produced for it.
- Handshake:
  - I_wb_stb sampled high at edge N → O_wb_ack high for exactly the cycle after N. O_wb_dat is registered and valid in that cycle.
  - Strobes held high on consecutive edges are each acked, giving one ack per cycle.
  - Writes take effect at edge N.
  - O_wb_dat holds its last value when no ack is pending.
- Prescaler:
  - While EN = 1, the prescaler counts 0..PRESCALE. A tick occurs on the edge where the prescaler count equals PRESCALE, and the count returns to 0.
  - PRESCALE = 0 gives a tick every cycle; 255 gives one tick every 256 cycles.
  - While EN = 0, the prescaler count and COUNTER hold.
  - A write to PRESCALE also clears the prescaler count.
- Counter:
  - On a tick, COUNTER increments by 1 modulo 2^32; 0xFFFFFFFF wraps to 0 with no flag.
  - A bus write to a COUNTER byte at the same edge as a tick: the written byte takes the bus value and the remaining bytes take the incremented value.
- Compare:
  - PEND sets on the edge where a tick makes the new COUNTER value equal COMPARE.
  - Writes to COUNTER never set PEND.
  - A write to any COMPARE byte clears PEND. If a match occurs at the same edge, set wins.
  - A W1C of PEND at the same edge as a match: set wins.
- Interrupt:
  - O_irq = PEND & IE, registered, so it rises one cycle after PEND sets.
  - Clearing IE drops O_irq next cycle; PEND is retained.
- Simultaneous access: a read at the edge where COUNTER changes returns the pre-edge value.

Optional Feature:
- Macro TIMER_SNAPSHOT_EN.
- Defined:
  - A read of COUNTER byte 0 returns the live byte 0 and copies the full 32-bit COUNTER into a shadow register.
  - Reads of bytes 1..3 return shadow bytes, giving a tear-free 32-bit value across carries.
  - Shadow resets to 0.
- Undefined: bytes 1..3 return live COUNTER bytes, no shadow register.

Test Plan:
- Reset: hold I_reset_n = 0 mid-read with stb high → ack = 0, irq = 0, dat = 0. Release → read adr 4..7 returns FF FF FF FF; CTRL reads 0x00.
- Handshake: stb high 3 consecutive cycles, reading adr 9, 8, 0 after reset → ack high exactly 3 cycles, each one cycle after its strobe. Data 0x00, 0x00, 0x00; stall always 0.
- Prescale and match:
  - Setup: PRESCALE = 3, COMPARE = 5, CTRL = 0x03.
  - Expected: COUNTER increments every 4 cycles; PEND sets when COUNTER becomes 5, about 20 cycles after enable; O_irq high one cycle later.
  - Write CTRL = 0x07 → O_irq low next cycle, CTRL reads 0x03.
- Wrap: write COUNTER = FFFFFFFE, PRESCALE = 0, COMPARE = 0, CTRL = 0x03 → COUNTER reads 0 after two ticks, PEND set, irq raised.
- Collision: in the same cycle as a match tick, write COMPARE byte 0 → PEND ends set (set wins). A compare write one cycle later → PEND cleared.
- Snapshot (TIMER_SNAPSHOT_EN): COUNTER = 0x000000FF, EN = 1, PRESCALE = 0; read byte 0 then byte 1 while the carry occurs → returns FF, 00 (shadow). Without the macro, the byte 1 read returns 01.

Source files
------------

// File: rtl/timer_wb8.sv
// 32-bit prescaled timer with compare interrupt, 8-bit Wishbone responder.
// Define TIMER_SNAPSHOT_EN to latch a tear-free COUNTER shadow on byte-0 reads.
module timer_wb8 #(
    parameter logic [31:0] COUNTER_RESET = 32'h0000_0000,
    parameter logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF
) (
    input  logic       I_wb_clk,
    input  logic       I_reset_n,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    input  logic [3:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    output logic [7:0] O_wb_dat,
    output logic       O_wb_ack,
    output logic       O_wb_stall,
    output logic       O_irq
);

    logic [31:0] counter_q, counter_d;
    logic [31:0] compare_q, compare_d;
    logic        en_q, en_d, ie_q, ie_d, pend_q, pend_d;
    logic [7:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic        ack_q, ack_d, irq_q, irq_d;
    logic [7:0]  dat_q, dat_d;
    logic        wr, rd, tick, match, pend_clr;
    logic [31:0] cnt_inc;
    logic [31:0] rd_counter;
    logic [7:0]  rdata;

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (rd && I_wb_adr == 4'd0) shadow_d = counter_q;
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) shadow_q <= 32'd0;
        else            shadow_q <= shadow_d;
    end

    assign rd_counter = shadow_q;
`else
    assign rd_counter = counter_q;
`endif

    assign O_wb_dat   = dat_q;
    assign O_wb_ack   = ack_q;
    assign O_wb_stall = 1'b0;
    assign O_irq      = irq_q;

    always_comb begin
        wr       = I_wb_stb & I_wb_we;
        rd       = I_wb_stb & ~I_wb_we;
        tick     = en_q && (pcnt_q == prescale_q);
        cnt_inc  = counter_q + 32'd1;
        match    = tick && (cnt_inc == compare_q);

        counter_d  = tick ? cnt_inc : counter_q;
        compare_d  = compare_q;
        en_d       = en_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        pend_clr   = 1'b0;
        pcnt_d     = pcnt_q;
        if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;

        // A bus byte write overrides only its own byte of the ticked counter.
        if (wr) begin
            case (I_wb_adr)
                4'd0: counter_d[7:0]   = I_wb_dat;
                4'd1: counter_d[15:8]  = I_wb_dat;
                4'd2: counter_d[23:16] = I_wb_dat;
                4'd3: counter_d[31:24] = I_wb_dat;
                4'd4: begin compare_d[7:0]   = I_wb_dat; pend_clr = 1'b1; end
                4'd5: begin compare_d[15:8]  = I_wb_dat; pend_clr = 1'b1; end
                4'd6: begin compare_d[23:16] = I_wb_dat; pend_clr = 1'b1; end
                4'd7: begin compare_d[31:24] = I_wb_dat; pend_clr = 1'b1; end
                4'd8: begin
                    en_d     = I_wb_dat[0];
                    ie_d     = I_wb_dat[1];
                    pend_clr = I_wb_dat[2];
                end
                4'd9: begin prescale_d = I_wb_dat; pcnt_d = 8'd0; end
                default: ;
            endcase
        end

        // Match set takes priority over any clear at the same edge.
        pend_d = match ? 1'b1 : (pend_clr ? 1'b0 : pend_q);

        rdata = 8'd0;
        case (I_wb_adr)
            4'd0: rdata = counter_q[7:0];
            4'd1: rdata = rd_counter[15:8];
            4'd2: rdata = rd_counter[23:16];
            4'd3: rdata = rd_counter[31:24];
            4'd4: rdata = compare_q[7:0];
            4'd5: rdata = compare_q[15:8];
            4'd6: rdata = compare_q[23:16];
            4'd7: rdata = compare_q[31:24];
            4'd8: rdata = {5'd0, pend_q, ie_q, en_q};
            4'd9: rdata = prescale_q;
            default: rdata = 8'd0;
        endcase

        dat_d = rd ? rdata : dat_q;
        ack_d = I_wb_stb;
        irq_d = pend_q & ie_q;
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            counter_q  <= COUNTER_RESET;
            compare_q  <= COMPARE_RESET;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            pend_q     <= 1'b0;
            prescale_q <= 8'd0;
            pcnt_q     <= 8'd0;
            ack_q      <= 1'b0;
            dat_q      <= 8'd0;
            irq_q      <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            compare_q  <= compare_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

endmodule
